// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int unsigned LEN_BYTES      = 4;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 little-endian packer: first byte of a group lands in bits [7:0].
// word shows the value including the byte being accepted, so the caller
// can capture a complete word on the same edge that word_ready is high.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [31:0] shreg;
  logic [1:0]  cnt;

  assign word       = {in_byte, shreg[31:8]};
  assign word_ready = in_en && (cnt == 2'(BYTES_PER_WORD - 1));

  // Shift accepted bytes in from the top and count them modulo 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (in_en) begin
      shreg <= word;
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed byte stream packed
// into little-endian words and written at byte addresses 0, 4, 8, ...
// The core is held in reset until the image is loaded.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 512
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            core_hold,
  output logic            done,
  output logic            error
);

  localparam int unsigned WIDX = $clog2(DEPTH + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
  logic [7:0] csum;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t          state, state_nxt;
  logic            accept;
  logic            pk_en;
  logic            pk_ready;
  logic [31:0]     pk_word;
  logic [31:0]     len;
  logic [WIDX-1:0] word_idx;
  logic [WIDX-1:0] word_idx_inc;
  logic            last_word;

  // Byte acceptance depends only on state (and reset), never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, LEN, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM:            in_ready = 1'b1;
`endif
        default:         in_ready = 1'b0;
      endcase
    end
  end

  assign accept       = in_valid && in_ready;
  assign pk_en        = accept && (state == IDLE || state == LEN || state == DATA);
  assign word_idx_inc = word_idx + WIDX'(1);
  assign last_word    = (32'(word_idx_inc) == len);

  // The same packer assembles the length field and then the payload words.
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_en      (pk_en),
    .in_byte    (in_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    core_hold = 1'b1;
    case (state)
      IDLE: if (accept) state_nxt = LEN;
      LEN: begin
        if (pk_ready) begin
          if (pk_word == '0)                state_nxt = END_ST;
          else if (pk_word > 32'(DEPTH))    state_nxt = ERROR;
          else                              state_nxt = DATA;
        end
      end
      DATA: if (pk_ready) state_nxt = WRITE;
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last_word ? END_ST : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (accept) state_nxt = (in_data == csum) ? DONE : ERROR;
`endif
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      ERROR: error = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Length, word index and the held write address/data; the write port
  // registers are loaded on the edge that completes a word so they stay
  // stable through WRITE and afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == LEN && pk_ready) len <= pk_word;
      if (state == DATA && pk_ready) begin
        mem_wdata <= pk_word;
        mem_addr  <= XLEN'(word_idx) << 2;
      end
      if (state == WRITE) word_idx <= word_idx_inc;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of payload bytes, restarted whenever the loader is idle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE)        csum <= '0;
    else if (state == DATA && accept) csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          hs_n       = 0;
  int          ready_viol = 0;

  always #5 clk = ~clk;

  imem_loader #(.XLEN(32), .DEPTH(512)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  // Observe writes and handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (in_ready) ready_viol++;
    end
    if (in_valid && in_ready) hs_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a byte and hold it until it is taken; in_valid stays high after.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wb;
    int h0;
    int bad;
    logic [31:0] ew;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    rst = 1'b0;
    #1;
    check("idle_ready",    32'(in_ready),  32'd1);

    // Two-word image.
    wb = wr_addr.size();
    send_word(32'd2);
    send_word(32'h06100093);
    send_word(32'h68000113);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    idle(3);
    check("img2_nwr",   32'(wr_addr.size() - wb), 32'd2);
    check("img2_addr0", wr_addr[wb],              32'h0);
    check("img2_data0", wr_data[wb],              32'h06100093);
    check("img2_addr1", wr_addr[wb+1],            32'h4);
    check("img2_data1", wr_data[wb+1],            32'h68000113);
    check("img2_done",  32'(done),                32'd1);
    check("img2_hold",  32'(core_hold),           32'd0);
    check("img2_error", 32'(error),               32'd0);
    check("img2_ready", 32'(in_ready),            32'd0);
    check("img2_addr_held", mem_addr,             32'h4);
    check("img2_data_held", mem_wdata,            32'h68000113);

    // Zero-length image.
    do_reset();
    wb = wr_addr.size();
    send_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("zero_wait_csum", 32'(done), 32'd0);
    send_byte(8'h00);
`endif
    check("zero_done",  32'(done), 32'd1);
    idle(2);
    check("zero_nwr",   32'(wr_addr.size() - wb), 32'd0);

    // Oversized image (N = DEPTH+1).
    do_reset();
    wb = wr_addr.size();
    send_word(32'd513);
    idle(2);
    check("big_error", 32'(error),     32'd1);
    check("big_hold",  32'(core_hold), 32'd1);
    check("big_ready", 32'(in_ready),  32'd0);
    check("big_done",  32'(done),      32'd0);
    check("big_nwr",   32'(wr_addr.size() - wb), 32'd0);

    // Full-size image streamed with in_valid held high throughout.
    do_reset();
    wb = wr_addr.size();
    h0 = hs_n;
    send_word(32'd512);
    for (int i = 0; i < 2048; i++) send_byte(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    in_data = 8'hAA;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_nwr",       32'(wr_addr.size() - wb), 32'd512);
    check("full_first",     wr_data[wb],              32'h03020100);
    check("full_last_addr", wr_addr[wb+511],          32'h7FC);
    check("full_last_data", wr_data[wb+511],          32'hFFFEFDFC);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      ew = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (wr_addr[wb+i] !== 32'(i*4) || wr_data[wb+i] !== ew) bad++;
    end
    check("full_contig", 32'(bad), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("full_hs", 32'(hs_n - h0), 32'd2053);
`else
    check("full_hs", 32'(hs_n - h0), 32'd2052);
`endif
    check("full_done",       32'(done),       32'd1);
    check("write_ready_low", 32'(ready_viol), 32'd0);

    // Reset in the middle of a payload, then a fresh one-word image.
    do_reset();
    send_word(32'd2);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i));
    do_reset();
    wb = wr_addr.size();
    check("midrst_done", 32'(done), 32'd0);
    send_word(32'd1);
    send_word(32'h0000006F);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h6F);
`endif
    idle(3);
    check("midrst_nwr",  32'(wr_addr.size() - wb), 32'd1);
    check("midrst_addr", wr_addr[wb],              32'h0);
    check("midrst_data", wr_data[wb],              32'h0000006F);
    check("midrst_fin",  32'(done),                32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    send_word(32'd1);
    send_word(32'h44332211);
    send_byte(8'h44);
    idle(2);
    check("csum_ok_done",  32'(done),  32'd1);
    check("csum_ok_error", 32'(error), 32'd0);
    do_reset();
    send_word(32'd1);
    send_word(32'h44332211);
    send_byte(8'h45);
    idle(2);
    check("csum_bad_error", 32'(error),     32'd1);
    check("csum_bad_hold",  32'(core_hold), 32'd1);
    check("csum_bad_done",  32'(done),      32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
